gate3_stim_checker: RTL and testbench

- Stimulus and response side of the 3-input gate PAR test designs.
- Drives three DUT input pins with an exhaustive 3-bit pattern and samples the DUT's registered output pin.
- Compares each sample against the expected gate function, delayed by the DUT latency, and reports pass/fail plus an error count.
- Sits on the tester FPGA, pin-wired to the DUT's gpio0..gpio2 (stimulus) and gpio3 (response), sharing gclk.

---
 rtl/gate_test_pkg.sv | 35 +++
 rtl/exp_delay_line.sv | 36 +++
 rtl/gate3_stim_checker.sv | 170 +++++++++++++++++
 tb/tb_gate3_stim_checker.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_test_pkg.sv
// Shared types and helpers for the 3-input gate PAR stimulus/response checker.
package gate_test_pkg;

    localparam int unsigned FUNC_AND = 0;
    localparam int unsigned FUNC_OR  = 1;
    localparam int unsigned FUNC_XOR = 2;

    localparam int unsigned VEC_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One expected-value slot travelling alongside the DUT latency
    typedef struct packed {
        logic             valid;
        logic             exp;
        logic [VEC_W-1:0] vec;
    } exp_entry_t;

    // Reference gate function applied to a stimulus vector
    function automatic logic exp_func(input int unsigned func, input logic [VEC_W-1:0] v);
        logic r;
        case (func)
            FUNC_OR:  r = |v;
            FUNC_XOR: r = ^v;
            default:  r = &v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/exp_delay_line.sv
// LATENCY-deep shift line that aligns expected values with the DUT response.
module exp_delay_line
    import gate_test_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic       gclk,
    input  logic       resetn,
    input  logic       clr,
    input  exp_entry_t din,
    output exp_entry_t dout
);

    exp_entry_t line [LATENCY];

    // Shift one slot per cycle; clr flushes every slot so stale entries never compare
    always_ff @(posedge gclk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                line[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                line[i] <= '0;
            end
        end else begin
            line[0] <= din;
            for (int i = 1; i < int'(LATENCY); i++) begin
                line[i] <= line[i-1];
            end
        end
    end

    assign dout = line[LATENCY-1];

endmodule

// File: rtl/gate3_stim_checker.sv
// Exhaustive 3-bit stimulus generator and registered-response checker for gate PAR tests.
module gate3_stim_checker
    import gate_test_pkg::*;
#(
    parameter int unsigned FUNC    = 0,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned REPEAT  = 4,
    parameter int unsigned ERR_W   = 8
) (
    input  logic             gclk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    output logic [2:0]       stim,
    input  logic             resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       first_fail
);

    localparam int unsigned SWP_W = 8;
    localparam int unsigned DRN_W = 4;

    // Reject unsupported configurations at elaboration
    if (FUNC > FUNC_XOR) begin : g_bad_func
        $error("gate3_stim_checker: FUNC must be 0, 1 or 2");
    end
    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
        $error("gate3_stim_checker: LATENCY must be 1..8");
    end
    if (REPEAT < 1 || REPEAT > 255) begin : g_bad_repeat
        $error("gate3_stim_checker: REPEAT must be 1..255");
    end

    state_t             state_q, state_d;
    logic [2:0]         stim_d;
    logic [SWP_W-1:0]   sweep_q, sweep_d;
    logic [DRN_W-1:0]   drain_q, drain_d;
    logic [ERR_W-1:0]   err_d;
    logic [2:0]         ff_d;
    logic               busy_d, done_d, pass_d;
    logic               clr_c, start_run_c, cmp_c, mismatch_c;
    exp_entry_t         push_c, line_out;

    exp_delay_line #(
        .LATENCY (LATENCY)
    ) u_line (
        .gclk   (gclk),
        .resetn (resetn),
        .clr    (clr_c),
        .din    (push_c),
        .dout   (line_out)
    );

    // Next-state, stimulus, counter and comparator logic
    always_comb begin
        state_d     = state_q;
        stim_d      = stim;
        sweep_d     = sweep_q;
        drain_d     = drain_q;
        clr_c       = 1'b0;
        start_run_c = 1'b0;
        push_c      = '0;

        case (state_q)
            ST_IDLE: begin
                stim_d  = '0;
                sweep_d = '0;
                clr_c   = 1'b1;
                if (start) begin
                    state_d     = ST_DRIVE;
                    start_run_c = 1'b1;
                end
            end
            ST_DRIVE: begin
                push_c.valid = 1'b1;
                push_c.exp   = exp_func(FUNC, stim);
                push_c.vec   = stim;
                if (stim == 3'd7) begin
                    if (sweep_q == SWP_W'(REPEAT - 1)) begin
                        // last vector of the run stays on the pins while the line drains
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end else begin
                        stim_d  = '0;
                        sweep_d = sweep_q + SWP_W'(1);
                    end
                end else begin
                    stim_d = stim + 3'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRN_W'(LATENCY - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + DRN_W'(1);
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d     = ST_DRIVE;
                    start_run_c = 1'b1;
                    stim_d      = '0;
                    sweep_d     = '0;
                    clr_c       = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // abort wins over everything, including a same-cycle start
        if (abort) begin
            state_d     = ST_IDLE;
            stim_d      = '0;
            start_run_c = 1'b0;
            clr_c       = 1'b1;
        end

        cmp_c      = line_out.valid && !abort;
        mismatch_c = cmp_c && (resp != line_out.exp);

        err_d = err_count;
        ff_d  = first_fail;
        if (start_run_c) begin
            err_d = '0;
            ff_d  = '0;
        end else if (mismatch_c) begin
            if (err_count != '1) begin
                err_d = err_count + ERR_W'(1);
            end
            if (err_count == '0) begin
                ff_d = line_out.vec;
            end
        end

        busy_d = (state_d == ST_DRIVE) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
        pass_d = (state_d == ST_DONE) && (err_d == '0);
    end

    // State and registered outputs
    always_ff @(posedge gclk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            stim       <= '0;
            sweep_q    <= '0;
            drain_q    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
        end else begin
            state_q    <= state_d;
            stim       <= stim_d;
            sweep_q    <= sweep_d;
            drain_q    <= drain_d;
            busy       <= busy_d;
            done       <= done_d;
            pass       <= pass_d;
            err_count  <= err_d;
            first_fail <= ff_d;
        end
    end

endmodule

// File: tb/tb_gate3_stim_checker.sv
// Directed bench for gate3_stim_checker with behavioural DUT models on the pins.
module tb_gate3_stim_checker;

    logic gclk;
    logic resetn;
    logic abort_off;

    logic       start0, start1, start2, start3, abort0;
    logic [2:0] stim0, stim1, stim2, stim3;
    logic       resp0, resp1, resp2, resp3;
    logic       busy0, busy1, busy2, busy3;
    logic       done0, done1, done2, done3;
    logic       pass0, pass1, pass2, pass3;
    logic [7:0] err0, err1, err2, err3;
    logic [2:0] ff0, ff1, ff2, ff3;

    logic stuck0;
    logic r0, x1a, x2a, x1b, x2b, r3;

    int checks;
    int errors;
    int n;

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    // AND3 checker: correct or stuck-at-0 registered DUT
    gate3_stim_checker #(.FUNC(0), .LATENCY(1), .REPEAT(4), .ERR_W(8)) u0 (
        .gclk(gclk), .resetn(resetn), .start(start0), .abort(abort0), .stim(stim0),
        .resp(resp0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail(ff0));

    // XOR3 checker matched to a two-stage DUT
    gate3_stim_checker #(.FUNC(2), .LATENCY(2), .REPEAT(4), .ERR_W(8)) u1 (
        .gclk(gclk), .resetn(resetn), .start(start1), .abort(abort_off), .stim(stim1),
        .resp(resp1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail(ff1));

    // XOR3 checker with latency one short of the two-stage DUT
    gate3_stim_checker #(.FUNC(2), .LATENCY(1), .REPEAT(4), .ERR_W(8)) u2 (
        .gclk(gclk), .resetn(resetn), .start(start2), .abort(abort_off), .stim(stim2),
        .resp(resp2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_fail(ff2));

    // AND3 checker against an inverting DUT for counter saturation
    gate3_stim_checker #(.FUNC(0), .LATENCY(1), .REPEAT(255), .ERR_W(8)) u3 (
        .gclk(gclk), .resetn(resetn), .start(start3), .abort(abort_off), .stim(stim3),
        .resp(resp3), .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .first_fail(ff3));

    // Behavioural DUTs on the far side of the pins
    always_ff @(posedge gclk or negedge resetn) begin
        if (!resetn) begin
            r0  <= 1'b0;
            x1a <= 1'b0;
            x2a <= 1'b0;
            x1b <= 1'b0;
            x2b <= 1'b0;
            r3  <= 1'b0;
        end else begin
            r0  <= &stim0;
            x1a <= ^stim1;
            x2a <= x1a;
            x1b <= ^stim2;
            x2b <= x1b;
            r3  <= ~(&stim3);
        end
    end

    assign resp0 = stuck0 ? 1'b0 : r0;
    assign resp1 = x2a;
    assign resp2 = x2b;
    assign resp3 = r3;

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic busy_of(input int idx);
        case (idx)
            0: return busy0;
            1: return busy1;
            2: return busy2;
            default: return busy3;
        endcase
    endfunction

    task automatic pulse(input int idx);
        case (idx)
            0: start0 = 1'b1;
            1: start1 = 1'b1;
            2: start2 = 1'b1;
            default: start3 = 1'b1;
        endcase
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        start3 = 1'b0;
    endtask

    // Count busy cycles of a run that has just started, bounded
    task automatic run_wait(input int idx, output int cnt);
        cnt = 0;
        while (busy_of(idx) && cnt < 3000) begin
            cnt++;
            tick();
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        resetn    = 1'b0;
        abort_off = 1'b0;
        abort0    = 1'b0;
        start0    = 1'b0;
        start1    = 1'b0;
        start2    = 1'b0;
        start3    = 1'b0;
        stuck0    = 1'b0;

        repeat (3) tick();
        check("rst_stim", 32'(stim0), 0);
        check("rst_busy", 32'(busy0), 0);
        check("rst_done", 32'(done0), 0);
        check("rst_pass", 32'(pass0), 0);
        check("rst_err", 32'(err0), 0);
        check("rst_ff", 32'(ff0), 0);
        resetn = 1'b1;
        tick();

        // Correct AND3 DUT
        pulse(0);
        check("and_first_stim", 32'(stim0), 0);
        run_wait(0, n);
        check("and_busy_cycles", 32'(n), 33);
        check("and_done", 32'(done0), 1);
        check("and_pass", 32'(pass0), 1);
        check("and_err", 32'(err0), 0);
        check("and_ff", 32'(ff0), 0);

        // Stuck-at-0 response, restarted straight from DONE
        stuck0 = 1'b1;
        pulse(0);
        check("stuck_busy", 32'(busy0), 1);
        check("stuck_done_low", 32'(done0), 0);
        run_wait(0, n);
        check("stuck_busy_cycles", 32'(n), 33);
        check("stuck_err", 32'(err0), 4);
        check("stuck_ff", 32'(ff0), 7);
        check("stuck_pass", 32'(pass0), 0);
        check("stuck_done", 32'(done0), 1);

        // Two-stage XOR3 DUT with matched latency
        pulse(1);
        run_wait(1, n);
        check("xor_l2_busy_cycles", 32'(n), 34);
        check("xor_l2_pass", 32'(pass1), 1);
        check("xor_l2_err", 32'(err1), 0);

        // Same DUT with latency one short: parity of previous vector seen
        pulse(2);
        run_wait(2, n);
        check("xor_l1_busy_cycles", 32'(n), 33);
        check("xor_l1_pass", 32'(pass2), 0);
        check("xor_l1_err", 32'(err2), 23);
        check("xor_l1_ff", 32'(ff2), 1);

        // Inverting DUT over 255 sweeps saturates the counter
        pulse(3);
        run_wait(3, n);
        check("inv_busy_cycles", 32'(n), 2041);
        check("inv_err_sat", 32'(err3), 255);
        check("inv_ff", 32'(ff3), 0);
        check("inv_pass", 32'(pass3), 0);
        check("inv_done", 32'(done3), 1);

        // Abort in the second sweep after one mismatch; counters hold
        pulse(0);
        repeat (9) tick();
        check("abort_pre_stim", 32'(stim0), 1);
        check("abort_pre_err", 32'(err0), 1);
        abort0 = 1'b1;
        tick();
        abort0 = 1'b0;
        check("abort_stim", 32'(stim0), 0);
        check("abort_busy", 32'(busy0), 0);
        check("abort_done", 32'(done0), 0);
        check("abort_err_hold", 32'(err0), 1);
        check("abort_ff_hold", 32'(ff0), 7);
        repeat (5) tick();
        check("abort_done_stays", 32'(done0), 0);
        check("abort_err_stays", 32'(err0), 1);

        // abort beats start in the same cycle
        start0 = 1'b1;
        abort0 = 1'b1;
        tick();
        start0 = 1'b0;
        abort0 = 1'b0;
        check("abort_prio_busy", 32'(busy0), 0);
        check("abort_prio_err", 32'(err0), 1);

        // Clean run after abort
        stuck0 = 1'b0;
        pulse(0);
        check("post_abort_err_clr", 32'(err0), 0);
        run_wait(0, n);
        check("post_abort_cycles", 32'(n), 33);
        check("post_abort_pass", 32'(pass0), 1);

        // Asynchronous reset mid-DRIVE
        stuck0 = 1'b1;
        pulse(0);
        repeat (3) tick();
        check("mid_pre_stim", 32'(stim0), 3);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_stim", 32'(stim0), 0);
        check("mid_rst_busy", 32'(busy0), 0);
        check("mid_rst_done", 32'(done0), 0);
        check("mid_rst_pass", 32'(pass0), 0);
        check("mid_rst_err", 32'(err0), 0);
        check("mid_rst_ff", 32'(ff0), 0);
        @(posedge gclk);
        #1;
        resetn = 1'b1;
        tick();
        pulse(0);
        run_wait(0, n);
        check("post_rst_cycles", 32'(n), 33);
        check("post_rst_err_exact", 32'(err0), 4);
        stuck0 = 1'b0;
        pulse(0);
        run_wait(0, n);
        check("post_rst_pass", 32'(pass0), 1);
        check("post_rst_err", 32'(err0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
